// File: rtl/ft_cmd_pkg.sv
// Shared constants, decoder state encoding and ack-byte helper for the FT245 command decoder.
// The ACK state only exists when CMD_ACK_EN is defined.
package ft_cmd_pkg;

    localparam logic [7:0] SYNC_BYTE     = 8'hA5;
    localparam logic [7:0] CMD_SET_PHASE = 8'h01;
    localparam logic [7:0] CMD_COMMIT    = 8'h02;
    localparam logic [7:0] CMD_BURST     = 8'h03;
    localparam logic [7:0] ACK_OK_MASK   = 8'h80;
    localparam logic [7:0] ACK_ERR       = 8'hEE;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_CMD,
        ST_ADDR,
        ST_COUNT,
        ST_DATA,
        ST_DONE
`ifdef CMD_ACK_EN
        , ST_ACK
`endif
    } state_t;

    function automatic logic [7:0] ack_byte(input logic err, input logic [7:0] cmd);
        return err ? ACK_ERR : (ACK_OK_MASK | cmd);
    endfunction

endpackage

// File: rtl/ft_cmd_decoder_if.sv
// Bus bundle between the command decoder and its RX FIFO, phase shadow bank and TX FIFO.
// master = decoder side, slave = FIFO / register-bank side.
interface ft_cmd_decoder_if #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int PHASE_W = 8
) ();
    // RX: rxfifo_rd is a one-cycle request; rxfifo_valid/rxfifo_data answer exactly one
    // cycle later; at most one request is outstanding. phase_wr, phase_commit and
    // txfifo_wr are single-cycle strobes with no back-pressure except txfifo_full.
    logic              rxfifo_rd;
    logic [DATA_W-1:0] rxfifo_data;
    logic              rxfifo_valid;
    logic              rxfifo_empty;

    logic               phase_wr;
    logic [ADDR_W-1:0]  phase_addr;
    logic [PHASE_W-1:0] phase_data;
    logic               phase_commit;

    logic [DATA_W-1:0] txfifo_data;
    logic              txfifo_wr;
    logic              txfifo_full;

    modport master (
        output rxfifo_rd, phase_wr, phase_addr, phase_data, phase_commit, txfifo_data, txfifo_wr,
        input  rxfifo_data, rxfifo_valid, rxfifo_empty, txfifo_full
    );

    modport slave (
        input  rxfifo_rd, phase_wr, phase_addr, phase_data, phase_commit, txfifo_data, txfifo_wr,
        output rxfifo_data, rxfifo_valid, rxfifo_empty, txfifo_full
    );
endinterface

// File: rtl/ft_rx_byte_reader.sv
// Single-outstanding RX FIFO reader: issues rxfifo_rd, tracks the pending read and
// presents the returned byte to the parser only when it answers our own request.
module ft_rx_byte_reader #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rxfifo_empty,
    input  logic              rxfifo_valid,
    input  logic [DATA_W-1:0] rxfifo_data,
    input  logic              accept_en,
    output logic              rxfifo_rd,
    output logic [DATA_W-1:0] byte_data,
    output logic              byte_valid
);

    logic pending_q, pending_d;

    // A valid with no read outstanding (e.g. one straddling reset) is dropped here.
    assign byte_valid = rxfifo_valid && pending_q;
    assign byte_data  = rxfifo_data;

    always_comb begin
        rxfifo_rd = !rst && accept_en && !rxfifo_empty && (!pending_q || byte_valid);
        pending_d = pending_q;
        if (rxfifo_rd) begin
            pending_d = 1'b1;
        end else if (byte_valid) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/ft_cmd_decoder.sv
// Host command frame parser: SYNC/CMD/payload bytes from the RX FIFO become phase writes
// and commit strobes. Define CMD_ACK_EN to return an ack byte per frame on the TX FIFO.
module ft_cmd_decoder
    import ft_cmd_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int NUM_CHANNELS   = 256,
    parameter int PHASE_W        = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    ft_cmd_decoder_if.master  bus,
    output logic [7:0]        err_cnt,
    output logic              busy,
    output state_t            state
);

    localparam int AW = $clog2(NUM_CHANNELS);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [AW:0]   NUM_CH   = (AW+1)'(NUM_CHANNELS);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [DATA_W-1:0] byte_data;
    logic              byte_valid;
    logic              accept_en;

    state_t             state_q, state_d;
    logic [AW:0]        addr_q, addr_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               burst_q, burst_d;
    logic [7:0]         cmd_q, cmd_d;
    logic               range_err_q, range_err_d;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic [7:0]         err_cnt_q, err_cnt_d;
    logic               phase_wr_q, phase_wr_d;
    logic [AW-1:0]      phase_addr_q, phase_addr_d;
    logic [PHASE_W-1:0] phase_data_q, phase_data_d;
    logic               commit_q, commit_d;
`ifdef CMD_ACK_EN
    logic [7:0]         ack_byte_q, ack_byte_d;
`endif

    logic tmo_active;
    logic frame_err;
    logic err_evt;

    ft_rx_byte_reader #(.DATA_W(DATA_W)) u_reader (
        .clk          (clk),
        .rst          (rst),
        .rxfifo_empty (bus.rxfifo_empty),
        .rxfifo_valid (bus.rxfifo_valid),
        .rxfifo_data  (bus.rxfifo_data),
        .accept_en    (accept_en),
        .rxfifo_rd    (bus.rxfifo_rd),
        .byte_data    (byte_data),
        .byte_valid   (byte_valid)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        burst_d      = burst_q;
        cmd_d        = cmd_q;
        range_err_d  = range_err_q;
        phase_wr_d   = 1'b0;
        phase_addr_d = phase_addr_q;
        phase_data_d = phase_data_q;
        commit_d     = 1'b0;
        frame_err    = 1'b0;
        err_evt      = 1'b0;
`ifdef CMD_ACK_EN
        ack_byte_d   = ack_byte_q;
`endif

        tmo_active = (state_q != ST_HUNT);
`ifdef CMD_ACK_EN
        if (state_q == ST_ACK) tmo_active = 1'b0;
`endif
        tmo_d = (tmo_active && !byte_valid) ? tmo_q + 1'b1 : '0;

        case (state_q)
            ST_HUNT: begin
                if (byte_valid && byte_data == SYNC_BYTE) begin
                    state_d     = ST_CMD;
                    range_err_d = 1'b0;
                end
            end
            ST_CMD: begin
                if (byte_valid) begin
                    cmd_d = byte_data;
                    case (byte_data)
                        CMD_SET_PHASE: begin burst_d = 1'b0; state_d = ST_ADDR; end
                        CMD_BURST:     begin burst_d = 1'b1; state_d = ST_ADDR; end
                        CMD_COMMIT:    begin commit_d = 1'b1; state_d = ST_DONE; end
                        SYNC_BYTE:     state_d = ST_CMD;
                        default:       frame_err = 1'b1;
                    endcase
                end
            end
            ST_ADDR: begin
                if (byte_valid) begin
                    // Out-of-range starts clamp to NUM_CHANNELS so they can never alias back in.
                    addr_d = (32'(byte_data) >= NUM_CHANNELS) ? NUM_CH : (AW+1)'(byte_data);
                    if (burst_q) begin
                        state_d = ST_COUNT;
                    end else begin
                        cnt_d   = 8'd1;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_COUNT: begin
                if (byte_valid) begin
                    if (byte_data == '0) begin
                        frame_err = 1'b1;
                    end else begin
                        cnt_d   = byte_data;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (byte_valid) begin
                    if (addr_q < NUM_CH) begin
                        phase_wr_d   = 1'b1;
                        phase_addr_d = addr_q[AW-1:0];
                        phase_data_d = byte_data[PHASE_W-1:0];
                        addr_d       = addr_q + 1'b1;
                    end else if (!range_err_q) begin
                        range_err_d = 1'b1;
                        err_evt     = 1'b1;
                    end
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == 8'd1) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
`ifdef CMD_ACK_EN
                state_d    = ST_ACK;
                ack_byte_d = ack_byte(range_err_q, cmd_q);
`else
                state_d    = ST_HUNT;
`endif
            end
`ifdef CMD_ACK_EN
            ST_ACK: begin
                if (!bus.txfifo_full) state_d = ST_HUNT;
            end
`endif
            default: state_d = ST_HUNT;
        endcase

        if (tmo_active && !byte_valid && tmo_q == TMO_LAST) frame_err = 1'b1;

        if (frame_err) begin
            err_evt = 1'b1;
`ifdef CMD_ACK_EN
            state_d    = ST_ACK;
            ack_byte_d = ACK_ERR;
`else
            state_d    = ST_HUNT;
`endif
        end

        err_cnt_d = (err_evt && err_cnt_q != 8'hFF) ? err_cnt_q + 1'b1 : err_cnt_q;

        // Stop reading as soon as the frame ends so no byte lands in DONE/ACK.
        accept_en = (state_q != ST_DONE) && (state_d != ST_DONE);
`ifdef CMD_ACK_EN
        if (state_q == ST_ACK || state_d == ST_ACK) accept_en = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_HUNT;
            addr_q       <= '0;
            cnt_q        <= '0;
            burst_q      <= 1'b0;
            cmd_q        <= '0;
            range_err_q  <= 1'b0;
            tmo_q        <= '0;
            err_cnt_q    <= '0;
            phase_wr_q   <= 1'b0;
            phase_addr_q <= '0;
            phase_data_q <= '0;
            commit_q     <= 1'b0;
`ifdef CMD_ACK_EN
            ack_byte_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            burst_q      <= burst_d;
            cmd_q        <= cmd_d;
            range_err_q  <= range_err_d;
            tmo_q        <= tmo_d;
            err_cnt_q    <= err_cnt_d;
            phase_wr_q   <= phase_wr_d;
            phase_addr_q <= phase_addr_d;
            phase_data_q <= phase_data_d;
            commit_q     <= commit_d;
`ifdef CMD_ACK_EN
            ack_byte_q   <= ack_byte_d;
`endif
        end
    end

    assign bus.phase_wr     = phase_wr_q;
    assign bus.phase_addr   = phase_addr_q;
    assign bus.phase_data   = phase_data_q;
    assign bus.phase_commit = commit_q;
    assign err_cnt          = err_cnt_q;
    assign busy             = (state_q != ST_HUNT);
    assign state            = state_q;

`ifdef CMD_ACK_EN
    assign bus.txfifo_wr   = (state_q == ST_ACK) && !bus.txfifo_full;
    assign bus.txfifo_data = ack_byte_q;
`else
    logic unused_tx_full;
    assign unused_tx_full  = bus.txfifo_full;
    assign bus.txfifo_wr   = 1'b0;
    assign bus.txfifo_data = '0;
`endif

endmodule

// File: tb/tb_ft_cmd_decoder.sv
// Scoreboarded bench for ft_cmd_decoder: frames built from a command-level model,
// expected writes/commits/acks queued at issue time and checked by a monitor.
module tb_ft_cmd_decoder;
  import ft_cmd_pkg::*;

  localparam int NUM_CH = 256;
  localparam int TMO    = 40;
  localparam int W      = 18;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ft_cmd_decoder_if #(.DATA_W(8), .ADDR_W(8), .PHASE_W(8)) bus ();
  logic [7:0] err_cnt;
  logic       busy;
  state_t     state;

  ft_cmd_decoder #(
    .DATA_W(8), .NUM_CHANNELS(NUM_CH), .PHASE_W(8), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .err_cnt(err_cnt), .busy(busy), .state(state)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [7:0]   ack_q[$];
  logic [7:0]   rx_q[$];
  int           exp_err = 0;
  int           n_checks = 0;
  int           n_pass = 0;
  bit           stall_en = 0;
  bit           stray_req = 0;
  logic         rd_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- RX FIFO model ----------------
  initial begin
    bus.rxfifo_valid = 1'b0;
    bus.rxfifo_data  = 8'h00;
    bus.rxfifo_empty = 1'b1;
    forever begin
      @(negedge clk);
      rd_seen = bus.rxfifo_rd;
      @(posedge clk);
      #1;
      if (rd_seen && rx_q.size() > 0) begin
        bus.rxfifo_valid = 1'b1;
        bus.rxfifo_data  = rx_q.pop_front();
      end else if (rd_seen) begin
        check("rx_underflow", 32'(rd_seen), 32'(0));
        bus.rxfifo_valid = 1'b0;
      end else if (stray_req) begin
        bus.rxfifo_valid = 1'b1;
        bus.rxfifo_data  = SYNC_BYTE;
        stray_req = 0;
      end else begin
        bus.rxfifo_valid = 1'b0;
      end
      bus.rxfifo_empty = (rx_q.size() == 0) || (stall_en && $urandom_range(0, 3) == 0);
    end
  end

  // ---------------- monitor ----------------
  task automatic compare_event(input string name, input logic [W-1:0] got);
    if (exp_q.size() == 0) check({name, "_unexpected"}, 32'(got), 32'(0));
    else check(name, 32'(got), 32'(exp_q.pop_front()));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.phase_wr) compare_event("phase_wr", {2'd1, bus.phase_addr, bus.phase_data});
        if (bus.phase_commit) compare_event("phase_commit", {2'd2, 16'h0000});
`ifdef CMD_ACK_EN
        if (bus.txfifo_wr) begin
          if (bus.txfifo_full) check("wr_while_full", 32'(bus.txfifo_full), 32'(0));
          if (ack_q.size() == 0) check("ack_unexpected", 32'(bus.txfifo_data), 32'h100);
          else check("ack_byte", 32'(bus.txfifo_data), 32'(ack_q.pop_front()));
        end
        if (state == ST_ACK && bus.rxfifo_rd) check("rd_in_ack", 32'(bus.rxfifo_rd), 32'(0));
`else
        if (bus.txfifo_wr || bus.txfifo_data != 8'h00)
          check("tx_tied_low", 32'({bus.txfifo_wr, bus.txfifo_data}), 32'(0));
`endif
      end
    end
  end

  // ---------------- driver tasks (command-level model) ----------------
  task automatic push(input logic [7:0] b);
    rx_q.push_back(b);
  endtask

  task automatic bump_err();
    exp_err = (exp_err == 255) ? 255 : exp_err + 1;
    ack_q.push_back(8'hEE);
  endtask

  task automatic frame_set(input logic [7:0] a, input logic [7:0] ph);
    push(8'hA5); push(8'h01); push(a); push(ph);
    exp_q.push_back({2'd1, a, ph});
    ack_q.push_back(8'h81);
  endtask

  task automatic frame_burst(input int start, input int n, input logic [7:0] first,
                             input logic [7:0] step);
    logic       hit;
    logic [7:0] d;
    hit = 1'b0;
    d = first;
    push(8'hA5); push(8'h03); push(8'(start)); push(8'(n));
    for (int i = 0; i < n; i++) begin
      push(d);
      if (start + i < NUM_CH) exp_q.push_back({2'd1, 8'(start + i), d});
      else hit = 1'b1;
      d = d + step;
    end
    if (hit) bump_err();
    else ack_q.push_back(8'h83);
  endtask

  task automatic frame_commit();
    push(8'hA5); push(8'h02);
    exp_q.push_back({2'd2, 16'h0000});
    ack_q.push_back(8'h82);
  endtask

  task automatic frame_bad(input logic [7:0] c);
    push(8'hA5); push(c);
    bump_err();
  endtask

  task automatic frame_zero_n(input logic [7:0] start);
    push(8'hA5); push(8'h03); push(start); push(8'h00);
    bump_err();
  endtask

  function automatic logic [7:0] rand_bad_cmd();
    logic [7:0] b;
    do b = 8'($urandom_range(0, 255));
    while (b == 8'h01 || b == 8'h02 || b == 8'h03 || b == 8'hA5);
    return b;
  endfunction

  task automatic garbage(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      do b = 8'($urandom_range(0, 255)); while (b == 8'hA5);
      push(b);
    end
  endtask

  task automatic wait_idle();
    int quiet;
    int cyc;
    quiet = 0;
    cyc = 0;
    while (quiet < 3 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (rx_q.size() == 0 && !bus.rxfifo_valid && !bus.rxfifo_rd && !busy) quiet++;
      else quiet = 0;
    end
    if (quiet < 3) check("idle_wait_expired", 32'(cyc), 32'(0));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    bus.txfifo_full = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rd", 32'(bus.rxfifo_rd), 32'(0));
    check("rst_phase_wr", 32'(bus.phase_wr), 32'(0));
    check("rst_commit", 32'(bus.phase_commit), 32'(0));
    check("rst_err_cnt", 32'(err_cnt), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_txfifo_wr", 32'(bus.txfifo_wr), 32'(0));
    @(posedge clk);
    #1 rst = 1'b0;

    // single SET_PHASE
    frame_set(8'h05, 8'h7F);
    wait_idle();
    check("set_err_cnt", 32'(err_cnt), 32'(exp_err));
    check("set_busy", 32'(busy), 32'(0));

    // burst of three then a commit
    frame_burst(10, 3, 8'h11, 8'h11);
    frame_commit();
    wait_idle();
    check("burst_err_cnt", 32'(err_cnt), 32'(exp_err));

    // leading garbage and double sync
    push(8'h00); push(8'hFF); push(8'hA5); push(8'hA5); push(8'h01); push(8'h00); push(8'h01);
    exp_q.push_back({2'd1, 8'h00, 8'h01});
    ack_q.push_back(8'h81);
    wait_idle();
    check("resync_err_cnt", 32'(err_cnt), 32'(exp_err));

    // unknown command
    frame_bad(8'h07);
    wait_idle();
    check("badcmd_err_cnt", 32'(err_cnt), 32'(exp_err));
    check("badcmd_state", 32'(state), 32'(ST_HUNT));

    // burst crossing the top channel
    frame_burst(255, 2, 8'hAA, 8'h11);
    wait_idle();
    check("range_err_cnt", 32'(err_cnt), 32'(exp_err));

    // inter-byte timeout
    push(8'hA5); push(8'h01);
    bump_err();
    wait_idle();
    check("timeout_err_cnt", 32'(err_cnt), 32'(exp_err));
    check("timeout_busy", 32'(busy), 32'(0));

    // zero-length burst
    frame_zero_n(8'h20);
    wait_idle();
    check("zero_n_err_cnt", 32'(err_cnt), 32'(exp_err));

`ifdef CMD_ACK_EN
    // ack held off while the TX FIFO is full
    bus.txfifo_full = 1'b1;
    frame_set(8'h02, 8'h03);
    frame_commit();
    repeat (30) @(negedge clk);
    check("ack_hold_state", 32'(state), 32'(ST_ACK));
    check("ack_hold_rx_left", 32'(rx_q.size()), 32'(2));
    @(posedge clk);
    #1 bus.txfifo_full = 1'b0;
    wait_idle();
    check("ack_err_cnt", 32'(err_cnt), 32'(exp_err));
`endif

    // randomized frames with random FIFO stalls
    stall_en = 1;
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 5))
        0: garbage($urandom_range(1, 4));
        1: frame_set(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        2: frame_burst(($urandom_range(0, 3) == 0) ? $urandom_range(250, 255) : $urandom_range(0, 240),
                       $urandom_range(1, 8), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        3: frame_commit();
        4: frame_bad(rand_bad_cmd());
        default: frame_zero_n(8'($urandom_range(0, 255)));
      endcase
      wait_idle();
      check("rand_err_cnt", 32'(err_cnt), 32'(exp_err));
    end
    stall_en = 0;

    // reset in the middle of a burst
    push(8'hA5); push(8'h03); push(8'h10); push(8'h05); push(8'h31); push(8'h32);
    exp_q.push_back({2'd1, 8'h10, 8'h31});
    exp_q.push_back({2'd1, 8'h11, 8'h32});
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("midrst_writes_seen", 32'(exp_q.size()), 32'(0));
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_phase_wr", 32'(bus.phase_wr), 32'(0));
    check("midrst_rd", 32'(bus.rxfifo_rd), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_err_cnt", 32'(err_cnt), 32'(0));
    rx_q.delete();
    exp_err = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // stray valid with no read pending, then unsynced bytes, then a good frame
    stray_req = 1;
    repeat (3) @(posedge clk);
    push(8'h01); push(8'h33); push(8'h44);
    frame_set(8'h09, 8'h5A);
    wait_idle();
    check("postrst_err_cnt", 32'(err_cnt), 32'(exp_err));

    // error counter saturation
    for (int i = 0; i < 260; i++) frame_bad(8'h07);
    wait_idle();
    check("sat_err_cnt", 32'(err_cnt), 32'(255));

    check("exp_q_drained", 32'(exp_q.size()), 32'(0));
`ifdef CMD_ACK_EN
    check("ack_q_drained", 32'(ack_q.size()), 32'(0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
